// File: rtl/pb_step_pkg.sv
// Shared types and constants for the pushbutton step controller.
// The pb_step_ctrl top honours the PB_STEP_AUTO_REPEAT_EN macro (hold-to-repeat).
package pb_step_pkg;

    // Button FSM: a strobe is generated only on the RELEASED -> PRESSED edge.
    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } pb_state_t;

    // 5 ms debounce window at 100 MHz.
    localparam int DB_CYCLES_100MHZ      = 500000;
    localparam int DB_CNT_W_DEFAULT      = 20;
    // 0.5 s before auto-repeat kicks in, then 0.25 s between repeats.
    localparam int HOLD_CYCLES_DEFAULT   = 50000000;
    localparam int REPEAT_CYCLES_DEFAULT = 25000000;
    // Width of the step counter shown on the display.
    localparam int STEP_CNT_W            = 16;

    // Bits needed to hold values 0..n (never less than 1).
    function automatic int bits_for(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a saturating-window debouncer.
// Reusable for any slow, bouncy level input (pushbuttons, switches, gpi).
module sync_debounce
    import pb_step_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_100MHZ,
    parameter int CNT_W     = DB_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   din_s;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;

    assign din_s = sync_reg[SYNC_STAGES-1];
    assign level = level_reg;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples;
    // any sample that matches the current level restarts the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (din_s == level_reg) begin
            cnt_reg   <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= din_s;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pb_step_ctrl.sv
// Pushbutton single-step front end for the MIPS prototype: debounced button,
// one step strobe per press (or per tick in run mode) and a step counter.
// Define PB_STEP_AUTO_REPEAT_EN to add hold-to-repeat stepping.
module pb_step_ctrl
    import pb_step_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_100MHZ,
    parameter int CNT_W         = DB_CNT_W_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pb,
    input  logic                  run_mode,
    input  logic                  tick,
    output logic                  pb_level,
    output logic                  step,
    output logic [STEP_CNT_W-1:0] step_count
);

    pb_state_t             state_reg;
    logic                  step_reg;
    logic [STEP_CNT_W-1:0] step_count_reg;
    logic                  press;
    logic                  repeat_fire;

    // Invalid configurations (debounce counter too narrow, zero-length
    // windows) elaborate this empty, named scope so they are easy to spot.
    generate
        if ((64'd1 << CNT_W) <= 64'(DB_CYCLES) || DB_CYCLES < 1 ||
            HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        end
    endgenerate

    sync_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_sync_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (pb),
        .level (pb_level)
    );

`ifdef PB_STEP_AUTO_REPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = bits_for(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              repeating_reg;
    logic              hold_active;

    // Hold timing only runs while the button is held in manual-step mode.
    always_comb begin
        hold_active = (state_reg == PRESSED) && pb_level && !run_mode;
        repeat_fire = hold_active &&
                      (hold_cnt_reg == (repeating_reg ? REPEAT_LAST : HOLD_LAST));
    end

    // First repeat after HOLD_CYCLES, then every REPEAT_CYCLES until release.
    always_ff @(posedge clk) begin
        if (reset || !hold_active) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b0;
        end else if (repeat_fire) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b1;
        end else begin
            hold_cnt_reg  <= hold_cnt_reg + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // A press is the first cycle the debounced level is seen high while idle.
    always_comb begin
        press = ((state_reg == RELEASED) && pb_level) || repeat_fire;
    end

    // Button FSM, step select and step counter, all registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RELEASED;
            step_reg       <= 1'b0;
            step_count_reg <= '0;
        end else begin
            case (state_reg)
                RELEASED: if (pb_level)  state_reg <= PRESSED;
                PRESSED:  if (!pb_level) state_reg <= RELEASED;
                default:                 state_reg <= RELEASED;
            endcase
            step_reg <= run_mode ? tick : press;
            if (step_reg) begin
                step_count_reg <= step_count_reg + 1'b1;
            end
        end
    end

    assign step       = step_reg;
    assign step_count = step_count_reg;

endmodule
